max7219_rx: RTL and testbench

SPI responder that models the MAX7219 LED-driver input side in fabric. It samples the 3-wire load/clk/data bus driven by the `spi` master (`jd[3:1]` = {data, load, clk}) and assembles 16-bit frames. It decodes each frame into the MAX7219 register file (digit rows, decode mode, intensity, scan limit, shutdown, display test). It is the loopback and verification target for the UART→SPI LED path, and a drop-in display-state source for an on-board LED matrix driver.

---
 rtl/max7219_rx.sv | 148 ++++++++++++++
 tb/tb_max7219_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_rx.sv
// MAX7219 input-side model: synchronises load/clk/data, assembles 16-bit frames, decodes register writes.
// Strobes and register updates land SYNC_STAGES+1 i_clk edges after LOAD is first sampled high; no backpressure.
module max7219_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_spi_clk,
  input  logic        i_spi_data,
  input  logic        i_spi_load,
  output logic        o_stb,
  output logic [3:0]  o_addr,
  output logic [7:0]  o_data,
  output logic        o_frame_err,
  output logic [63:0] o_digits,
  output logic [7:0]  o_decode,
  output logic [3:0]  o_intensity,
  output logic [2:0]  o_scan_limit,
  output logic        o_shutdown,
  output logic        o_test
);

  logic [SYNC_STAGES-1:0] sck_sync_q, dat_sync_q, load_sync_q;
  logic                   sck_q, load_q;
  logic                   sck_s, dat_s, load_s;
  logic                   sck_rise, load_rise, load_fall;

  // D15:D12 never affect anything, so only the low 12 bits of the frame are kept.
  logic [11:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d, cnt_now;
  logic        stb_q, stb_d, err_q, err_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [63:0] digits_q, digits_d;
  logic [7:0]  decode_q, decode_d;
  logic [3:0]  intensity_q, intensity_d;
  logic [2:0]  scan_q, scan_d;
  logic        shut_q, shut_d, test_q, test_d;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_sync_q  <= '0;
      dat_sync_q  <= '0;
      load_sync_q <= '1;
      sck_q       <= 1'b0;
      load_q      <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_spi_clk};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], i_spi_data};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], i_spi_load};
      sck_q       <= sck_s;
      load_q      <= load_s;
    end
  end

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign load_s    = load_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_q;
  assign load_rise = load_s & ~load_q;
  assign load_fall = ~load_s & load_q;
  assign wr_addr   = sr_d[11:8];
  assign wr_data   = sr_d[7:0];

  always_comb begin
    sr_d        = sr_q;
    cnt_now     = cnt_q;
    stb_d       = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    digits_d    = digits_q;
    decode_d    = decode_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    shut_d      = shut_q;
    test_d      = test_q;
    // A bit arriving with the LOAD rising edge is shifted before the frame is judged.
    if (sck_rise && !load_q) begin
      sr_d = {sr_q[10:0], dat_s};
      if (cnt_q != 5'd17) cnt_now = cnt_q + 5'd1;
    end
    cnt_d = (load_fall || load_rise) ? 5'd0 : cnt_now;
    if (load_rise) begin
      if (cnt_now == 5'd16) begin
        stb_d  = 1'b1;
        addr_d = wr_addr;
        data_d = wr_data;
        if (wr_addr >= 4'h1 && wr_addr <= 4'h8)
          digits_d[8*(int'(wr_addr)-1) +: 8] = wr_data;
        case (wr_addr)
          4'h9:    decode_d    = wr_data;
          4'hA:    intensity_d = wr_data[3:0];
          4'hB:    scan_d      = wr_data[2:0];
          4'hC:    shut_d      = ~wr_data[0];
          4'hF:    test_d      = wr_data[0];
          default: ;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      digits_q    <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      shut_q      <= 1'b1;
      test_q      <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      digits_q    <= digits_d;
      decode_q    <= decode_d;
      intensity_q <= intensity_d;
      scan_q      <= scan_d;
      shut_q      <= shut_d;
      test_q      <= test_d;
    end
  end

  assign o_stb        = stb_q;
  assign o_frame_err  = err_q;
  assign o_addr       = addr_q;
  assign o_data       = data_q;
  assign o_digits     = digits_q;
  assign o_decode     = decode_q;
  assign o_intensity  = intensity_q;
  assign o_scan_limit = scan_q;
  assign o_shutdown   = shut_q;
  assign o_test       = test_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: table of frames with expected register state, pulse scoreboard, corner sequences.
module tb_max7219_rx;

  localparam int H = 10;  // SCK half period in i_clk cycles (SCK = f/20)

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_spi_clk = 1'b0;
  logic        i_spi_data = 1'b0;
  logic        i_spi_load = 1'b1;
  logic        o_stb, o_frame_err, o_shutdown, o_test;
  logic [3:0]  o_addr, o_intensity;
  logic [7:0]  o_data, o_decode;
  logic [63:0] o_digits;
  logic [2:0]  o_scan_limit;

  max7219_rx #(.SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_spi_clk(i_spi_clk), .i_spi_data(i_spi_data),
    .i_spi_load(i_spi_load), .o_stb(o_stb), .o_addr(o_addr), .o_data(o_data),
    .o_frame_err(o_frame_err), .o_digits(o_digits), .o_decode(o_decode),
    .o_intensity(o_intensity), .o_scan_limit(o_scan_limit), .o_shutdown(o_shutdown),
    .o_test(o_test)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       err;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [16:0] v;
    int          n;
    bit          simul;
    logic [63:0] dig;
    logic [7:0]  dec;
    logic [3:0]  inten;
    logic [2:0]  scan;
    logic        shut;
    logic        test;
  } vec_t;

  exp_t       sbq[$];
  int         checks = 0, failures = 0, pushed = 0, popped = 0;
  logic [3:0] exp_addr = '0;
  logic [7:0] exp_data = '0;
  vec_t       tbl[16];
  vec_t       cur;

  always @(negedge i_clk) begin
    if (!i_rst && (o_stb || o_frame_err)) begin
      exp_t e;
      bit   ok;
      checks++;
      e  = '0;
      ok = (sbq.size() != 0);
      if (ok) begin
        e  = sbq.pop_front();
        ok = (o_frame_err == e.err) && (o_stb == !e.err) && (o_addr == e.addr) && (o_data == e.data);
      end
      popped++;
      if (!ok) begin
        failures++;
        $display("FAIL pulse#%0d: got stb=%0b err=%0b addr=%h data=%h, want err=%0b addr=%h data=%h (queued=%0b)",
                 popped, o_stb, o_frame_err, o_addr, o_data, e.err, e.addr, e.data, e != '0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_regs(input string tag, input vec_t e);
    chk({tag, " digits"}, o_digits, e.dig);
    chk({tag, " decode"}, 64'(o_decode), 64'(e.dec));
    chk({tag, " intensity"}, 64'(o_intensity), 64'(e.inten));
    chk({tag, " scan_limit"}, 64'(o_scan_limit), 64'(e.scan));
    chk({tag, " shutdown"}, 64'(o_shutdown), 64'(e.shut));
    chk({tag, " test"}, 64'(o_test), 64'(e.test));
  endtask

  task automatic push_exp(input logic [16:0] v, input int n);
    exp_t e;
    if (n == 16) begin
      exp_addr = v[11:8];
      exp_data = v[7:0];
      e = '{1'b0, exp_addr, exp_data};
    end else begin
      e = '{1'b1, exp_addr, exp_data};
    end
    sbq.push_back(e);
    pushed++;
  endtask

  task automatic shift(input logic [16:0] v, input int n, input bit last_with_load);
    for (int i = n - 1; i >= 0; i--) begin
      i_spi_data = v[i];
      tick(H);
      i_spi_clk = 1'b1;
      if (last_with_load && i == 0) i_spi_load = 1'b1;
      tick(H);
      i_spi_clk = 1'b0;
    end
  endtask

  task automatic frame(input logic [16:0] v, input int n, input bit simul, input int gap);
    i_spi_load = 1'b0;
    tick(H);
    push_exp(v, n);
    shift(v, n, simul);
    if (!simul) begin
      tick(H);
      i_spi_load = 1'b1;
    end
    tick(gap);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && popped != pushed; k++) tick(1);
    chk({tag, " pulse count"}, 64'(popped), 64'(pushed));
  endtask

  function automatic vec_t mk(input logic [16:0] v, input int n, input bit simul, input logic [63:0] dig,
                              input logic [7:0] dec, input logic [3:0] inten, input logic [2:0] scan,
                              input logic shut, input logic test);
    vec_t r;
    r.v = v; r.n = n; r.simul = simul; r.dig = dig; r.dec = dec;
    r.inten = inten; r.scan = scan; r.shut = shut; r.test = test;
    return r;
  endfunction

  initial begin
    logic [63:0] lb_dig;
    logic [7:0]  pat;
    tbl[0]  = mk(17'h00C01, 16, 0, 64'h0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    tbl[1]  = mk(17'h00355, 16, 0, 64'h0000_0000_0055_0000, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    tbl[2]  = mk(17'h00A0F, 16, 0, 64'h0000_0000_0055_0000, 8'h00, 4'hF, 3'd0, 1'b0, 1'b0);
    tbl[3]  = mk(17'h00300, 16, 0, 64'h0, 8'h00, 4'hF, 3'd0, 1'b0, 1'b0);
    tbl[4]  = mk(17'h0F355, 16, 0, 64'h0000_0000_0055_0000, 8'h00, 4'hF, 3'd0, 1'b0, 1'b0);
    tbl[5]  = mk(17'h00A01, 15, 0, 64'h0000_0000_0055_0000, 8'h00, 4'hF, 3'd0, 1'b0, 1'b0);
    tbl[6]  = mk(17'h00C00, 17, 0, 64'h0000_0000_0055_0000, 8'h00, 4'hF, 3'd0, 1'b0, 1'b0);
    tbl[7]  = mk(17'h00D77, 16, 0, 64'h0000_0000_0055_0000, 8'h00, 4'hF, 3'd0, 1'b0, 1'b0);
    tbl[8]  = mk(17'h00F01, 16, 0, 64'h0000_0000_0055_0000, 8'h00, 4'hF, 3'd0, 1'b0, 1'b1);
    tbl[9]  = mk(17'h00F00, 16, 0, 64'h0000_0000_0055_0000, 8'h00, 4'hF, 3'd0, 1'b0, 1'b0);
    tbl[10] = mk(17'h00907, 16, 0, 64'h0000_0000_0055_0000, 8'h07, 4'hF, 3'd0, 1'b0, 1'b0);
    tbl[11] = mk(17'h00B03, 16, 1, 64'h0000_0000_0055_0000, 8'h07, 4'hF, 3'd3, 1'b0, 1'b0);
    tbl[12] = mk(17'h00000, 16, 0, 64'h0000_0000_0055_0000, 8'h07, 4'hF, 3'd3, 1'b0, 1'b0);
    tbl[13] = mk(17'h00C00, 16, 0, 64'h0000_0000_0055_0000, 8'h07, 4'hF, 3'd3, 1'b1, 1'b0);
    tbl[14] = mk(17'h00805, 16, 0, 64'h0500_0000_0055_0000, 8'h07, 4'hF, 3'd3, 1'b1, 1'b0);
    tbl[15] = mk(17'h00C01, 16, 0, 64'h0500_0000_0055_0000, 8'h07, 4'hF, 3'd3, 1'b0, 1'b0);

    tick(5);
    cur = mk(17'h0, 0, 0, 64'h0, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0);
    check_regs("reset", cur);
    chk("reset stb", 64'(o_stb), 64'h0);
    chk("reset frame_err", 64'(o_frame_err), 64'h0);
    chk("reset addr/data", 64'({o_addr, o_data}), 64'h0);
    i_rst = 1'b0;
    tick(5);

    for (int k = 0; k < 16; k++) begin
      if (k == 7) begin
        // SCK activity with LOAD high must neither shift nor count.
        i_spi_data = 1'b1;
        for (int t = 0; t < 3; t++) begin
          i_spi_clk = 1'b1; tick(H);
          i_spi_clk = 1'b0; tick(H);
        end
        chk("sck while load high", 64'(popped), 64'(pushed));
        check_regs("sck while load high", cur);
      end
      cur = tbl[k];
      frame(cur.v, cur.n, cur.simul, 4);
      drain($sformatf("row%0d", k));
      check_regs($sformatf("row%0d", k), cur);
    end

    // Reset in the middle of 0x0C01 after 8 bits; the remaining 8 bits then form a short frame.
    i_spi_load = 1'b0;
    tick(H);
    shift(17'h0000C, 8, 0);
    i_rst = 1'b1;
    tick(2);
    cur = mk(17'h0, 0, 0, 64'h0, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0);
    check_regs("mid-frame reset", cur);
    chk("mid-frame reset addr/data", 64'({o_addr, o_data}), 64'h0);
    i_rst = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    tick(H);
    push_exp(17'h00001, 8);
    shift(17'h00001, 8, 0);
    tick(H);
    i_spi_load = 1'b1;
    tick(4);
    drain("after reset");
    check_regs("after reset", cur);

    // All eight digits back to back with a short LOAD high time.
    lb_dig = '0;
    for (int n = 1; n <= 8; n++) begin
      pat = 8'(n * 37 + 3);
      lb_dig[8*n-1 -: 8] = pat;
      frame({5'b0, 4'(n), pat}, 16, 0, 4);
    end
    drain("loopback");
    cur.dig = lb_dig;
    check_regs("loopback", cur);
    chk("final queue empty", 64'(sbq.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
